s2_serial_receiver: RTL and testbench

Receives the serial frame stream driven on sen/sd by the upstream RB1 serializer stage. Deserializes each frame into a 3-bit address and an 18-bit data word, and writes the word into register bank RB2 (8 words x 18 bits). Raises S2_done once every RB2 location has been written at least once. Sits directly downstream of the serializer and is the last stage before RB2 is read back by the checker.

---
 rtl/s2_serial_receiver_if.sv | 29 ++
 rtl/s2_serial_receiver.sv | 140 ++++++++++++++
 tb/tb_s2_serial_receiver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/s2_serial_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : s2_serial_receiver_if
// Brief    : Serial frame input and RB2 write-port bundle for the S2 receiver.
// Revision : 1.0
// ============================================================================
interface s2_serial_receiver_if #(
    parameter int FRAME_ADDR_W = 3,
    parameter int FRAME_DATA_W = 18
);
    logic                    sen;
    logic                    sd;
    logic                    RB2_RW;
    logic [FRAME_ADDR_W-1:0] RB2_A;
    logic [FRAME_DATA_W-1:0] RB2_D;
    logic                    S2_done;
    logic                    frame_err;

    modport master (
        output sen, sd,
        input  RB2_RW, RB2_A, RB2_D, S2_done, frame_err
    );

    modport slave (
        input  sen, sd,
        output RB2_RW, RB2_A, RB2_D, S2_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/s2_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module   : s2_serial_receiver
// Brief    : Deserializes addr/data frames from sen/sd and writes them to RB2.
// Revision : 1.0
// ============================================================================
module s2_serial_receiver #(
    parameter int FRAME_ADDR_W = 3,
    parameter int FRAME_DATA_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    s2_serial_receiver_if.slave bus
);
    localparam int FRAME_W   = FRAME_ADDR_W + FRAME_DATA_W;
    localparam int CNT_W     = $clog2(FRAME_W);
    localparam int NUM_WORDS = 1 << FRAME_ADDR_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_W-2:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_WORDS-1:0]    valid_q, valid_d;
    logic                    rw_q, rw_d;
    logic [FRAME_ADDR_W-1:0] addr_q, addr_d;
    logic [FRAME_DATA_W-1:0] data_q, data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [FRAME_W-1:0]      w_frame;
    logic [NUM_WORDS-1:0]    w_onehot;
    logic [NUM_WORDS-1:0]    w_valid_set;

    always_comb begin
        // Only the previous FRAME_W-1 bits are kept; the last bit comes straight from sd.
        w_frame            = {shreg_q, bus.sd};
        w_onehot           = '0;
        w_onehot[addr_q]   = 1'b1;
        w_valid_set        = valid_q | w_onehot;

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rw_d    = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.sen) begin
                    shreg_d = w_frame[FRAME_W-2:0];
                    cnt_d   = CNT_W'(1);
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.sen) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_BIT) begin
                    rw_d    = 1'b0;
                    addr_d  = w_frame[FRAME_W-1 -: FRAME_ADDR_W];
                    data_d  = w_frame[FRAME_DATA_W-1:0];
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    shreg_d = w_frame[FRAME_W-2:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                valid_d = w_valid_set;
                // Completion takes priority over an overlong-frame error.
                if (&w_valid_set) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (bus.sen) begin
                    state_d = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.sen) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.RB2_RW    = rw_q;
    assign bus.RB2_A     = addr_q;
    assign bus.RB2_D     = data_q;
    assign bus.S2_done   = done_q;
    assign bus.frame_err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_s2_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2_serial_receiver
// Brief    : Directed bench with a run-length frame model for s2_serial_receiver.
// Revision : 1.0
// ============================================================================
module tb_s2_serial_receiver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    s2_serial_receiver_if #(.FRAME_ADDR_W(3), .FRAME_DATA_W(18)) bus ();

    s2_serial_receiver #(.FRAME_ADDR_W(3), .FRAME_DATA_W(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a write happens when a run of sen=0 samples reaches 21,
    // an error when a run ends short of 21 or grows to 22, all frozen once done.
    int          m_run;
    logic [20:0] m_bits;
    logic        m_pend, m_done, m_rw, m_err;
    logic [2:0]  m_a;
    logic [17:0] m_d;
    logic [7:0]  m_valid;

    initial begin
        forever begin
            if (!rst) begin
                m_run = 0; m_bits = '0; m_pend = 0; m_done = 0;
                m_rw = 1; m_err = 0; m_a = '0; m_d = '0; m_valid = '0;
            end else if (!m_done) begin
                m_rw  = 1;
                m_err = 0;
                if (m_pend) begin
                    m_valid[m_a] = 1'b1;
                    m_pend = 0;
                    if (m_valid == 8'hFF) m_done = 1;
                end
                if (!m_done) begin
                    if (!bus.sen) begin
                        m_run++;
                        m_bits = {m_bits[19:0], bus.sd};
                        if (m_run == 21) begin
                            m_rw = 0; m_a = m_bits[20:18]; m_d = m_bits[17:0]; m_pend = 1;
                        end else if (m_run == 22) begin
                            m_err = 1;
                        end
                    end else begin
                        if (m_run > 0 && m_run < 21) m_err = 1;
                        m_run = 0;
                    end
                end
            end
            @(posedge clk or negedge rst);
        end
    end

    // Observed RB2 contents and event counts, taken from the DUT outputs.
    logic [17:0] ram [8];
    int          writes;
    int          errs;

    initial begin
        forever begin
            @(negedge clk);
            check("RB2_RW",    32'(bus.RB2_RW),    32'(m_rw));
            check("RB2_A",     32'(bus.RB2_A),     32'(m_a));
            check("RB2_D",     32'(bus.RB2_D),     32'(m_d));
            check("S2_done",   32'(bus.S2_done),   32'(m_done));
            check("frame_err", 32'(bus.frame_err), 32'(m_err));
            if (bus.RB2_RW === 1'b0) begin
                ram[bus.RB2_A] = bus.RB2_D;
                writes++;
            end
            if (bus.frame_err === 1'b1) errs++;
        end
    end

    task automatic clear_obs();
        for (int i = 0; i < 8; i++) ram[i] = '0;
        writes = 0;
        errs   = 0;
    endtask

    task automatic cyc(input logic s, input logic d);
        bus.sen = s;
        bus.sd  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] a, input logic [17:0] d, input int extra);
        logic [20:0] f;
        f = {a, d};
        for (int i = 20; i >= 0; i--) cyc(1'b0, f[i]);
        for (int i = 0; i < extra; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check("rst_RW",   32'(bus.RB2_RW),    32'd1);
        check("rst_A",    32'(bus.RB2_A),     32'd0);
        check("rst_D",    32'(bus.RB2_D),     32'd0);
        check("rst_done", 32'(bus.S2_done),   32'd0);
        check("rst_err",  32'(bus.frame_err), 32'd0);
        bus.sen = 1'b1;
        bus.sd  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        rst = 1'b1;
        cyc(1'b1, 1'b0);
    endtask

    logic [17:0] dat [8];
    logic [2:0]  dup_order [9];
    logic [20:0] f7;

    initial begin
        bus.sen = 1'b1;
        bus.sd  = 1'b0;
        clear_obs();
        dat[0] = 18'h0A0A0; dat[1] = 18'h1B1B1; dat[2] = 18'h2C2C2; dat[3] = 18'h3D3D3;
        dat[4] = 18'h04E4E; dat[5] = 18'h15F5F; dat[6] = 18'h26161; dat[7] = 18'h37272;
        @(posedge clk);
        #1;

        // Single frame and its write latency.
        do_reset();
        send(3'b101, 18'h2A5C3, 0);
        check("single_rw_low", 32'(bus.RB2_RW), 32'd0);
        check("single_addr",   32'(bus.RB2_A),  32'd5);
        check("single_data",   32'(bus.RB2_D),  32'h2A5C3);
        cyc(1'b1, 1'b0);
        check("single_rw_back", 32'(bus.RB2_RW), 32'd1);
        check("single_writes",  32'(writes),     32'd1);
        check("single_done",    32'(bus.S2_done), 32'd0);

        // Eight back-to-back frames fill the bank.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(3'(i), dat[i], 0);
            if (i == 7) check("done_not_yet", 32'(bus.S2_done), 32'd0);
            cyc(1'b1, 1'b0);
        end
        check("eight_done",   32'(bus.S2_done), 32'd1);
        check("eight_writes", 32'(writes),      32'd8);
        check("eight_errs",   32'(errs),        32'd0);
        for (int i = 0; i < 8; i++) check("eight_ram", 32'(ram[i]), 32'(dat[i]));
        send(3'd0, 18'h3FFFF, 0);
        cyc(1'b1, 1'b0);
        check("post_done_writes", 32'(writes),      32'd8);
        check("post_done_ram0",   32'(ram[0]),      32'h0A0A0);
        check("post_done_sticky", 32'(bus.S2_done), 32'd1);

        // Truncated frame followed by a good one, then an overlong frame.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'(i & 1));
        cyc(1'b1, 1'b0);
        send(3'd2, 18'h12345, 0);
        cyc(1'b1, 1'b0);
        check("trunc_errs",   32'(errs),   32'd1);
        check("trunc_writes", 32'(writes), 32'd1);
        check("trunc_ram2",   32'(ram[2]), 32'h12345);
        send(3'd3, 18'h2AAAA, 4);
        cyc(1'b1, 1'b0);
        check("long_errs",   32'(errs),   32'd2);
        check("long_writes", 32'(writes), 32'd2);
        check("long_ram3",   32'(ram[3]), 32'h2AAAA);

        // Duplicate address gives no extra credit toward done.
        do_reset();
        dup_order[0] = 3'd4; dup_order[1] = 3'd0; dup_order[2] = 3'd1;
        dup_order[3] = 3'd2; dup_order[4] = 3'd4; dup_order[5] = 3'd3;
        dup_order[6] = 3'd5; dup_order[7] = 3'd6; dup_order[8] = 3'd7;
        for (int i = 0; i < 9; i++) begin
            send(dup_order[i], (i == 0) ? 18'h00001 : (i == 4) ? 18'h3FFFF : dat[dup_order[i]], 0);
            cyc(1'b1, 1'b0);
            if (i == 7) check("dup_done_early", 32'(bus.S2_done), 32'd0);
        end
        check("dup_done",   32'(bus.S2_done), 32'd1);
        check("dup_ram4",   32'(ram[4]),      32'h3FFFF);
        check("dup_writes", 32'(writes),      32'd9);

        // Reset mid-frame, release with sen already low, then a frame to addr 7.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_RW",  32'(bus.RB2_RW),  32'd1);
        check("midrst_err", 32'(bus.frame_err), 32'd0);
        f7 = {3'd7, 18'h0F0F0};
        bus.sen = 1'b0;
        bus.sd  = f7[20];
        @(posedge clk);
        #1;
        clear_obs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 19; i >= 0; i--) cyc(1'b0, f7[i]);
        cyc(1'b1, 1'b0);
        check("midrst_writes", 32'(writes),      32'd1);
        check("midrst_ram7",   32'(ram[7]),      32'h0F0F0);
        check("midrst_valid",  32'(dut.valid_q), 32'h80);
        check("midrst_errs",   32'(errs),        32'd0);
        repeat (3) cyc(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
